// File: rtl/if_axi_rd_if.sv
// AXI4-Lite read-only bus bundle between the instruction-fetch unit and
// the instruction memory / interconnect.
//   araddr  : read address            (master -> slave)
//   arprot  : protection attributes   (master -> slave)
//   arvalid : AR valid                (master -> slave)
//   arready : AR ready                (slave  -> master)
//   rdata   : read data               (slave  -> master)
//   rresp   : read response           (slave  -> master)
//   rvalid  : R valid                 (slave  -> master)
//   rready  : R ready                 (master -> slave)
interface if_axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/if_axi_rd.sv
// Instruction-fetch AXI4-Lite read master. Issues one read per fetch
// request, returns the instruction with a one-cycle strobe, and drops the
// response of any fetch made stale by a redirect while it was in flight.
//
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous active-high reset
//   fetch_en     pipeline permits a new fetch
//   addr_instr   fetch address from the PC
//   jmp_en       redirect: the outstanding fetch becomes stale
//   axi_idle_if  fetch port idle (PC advances only while high)
//   instr        fetched instruction (holds between strobes)
//   instr_vld    one-cycle strobe: instr is valid
//   instr_err    qualifies instr_vld: bus error or misaligned access
//   axi          AXI4-Lite read bus (if_axi_rd_if.master)
//
// Optional build macro IF_ALIGN_CHECK_EN: when defined, a fetch whose
// address is not word aligned is answered locally with an error strobe and
// never reaches the bus. When undefined, low address bits are passed through.
module if_axi_rd #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr_instr,
  input  logic              jmp_en,
  output logic              axi_idle_if,
  output logic [DATA_W-1:0] instr,
  output logic              instr_vld,
  output logic              instr_err,
  if_axi_rd_if.master       axi
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] araddr_q, araddr_nxt;
  logic              arvalid_q, arvalid_nxt;
  logic              rready_q, rready_nxt;
  logic              idle_q, idle_nxt;
  logic              vld_q, vld_nxt;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] instr_q, instr_nxt;
  logic              discard_q, discard_nxt;

  // An error response must never let bus garbage into the pipeline.
  function automatic logic [DATA_W-1:0] resp_instr(
    input logic [1:0]        resp,
    input logic [DATA_W-1:0] data
  );
    return (resp == 2'b00) ? data : NOP_INSTR;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      idle_q    <= 1'b1;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      instr_q   <= NOP_INSTR;
      discard_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      araddr_q  <= araddr_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      idle_q    <= idle_nxt;
      vld_q     <= vld_nxt;
      err_q     <= err_nxt;
      instr_q   <= instr_nxt;
      discard_q <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    araddr_nxt  = araddr_q;
    arvalid_nxt = arvalid_q;
    rready_nxt  = rready_q;
    idle_nxt    = idle_q;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    instr_nxt   = instr_q;
    discard_nxt = discard_q;

    case (state)
      IDLE: begin
        // A redirect here is harmless: the PC already presents the new
        // target, so fetch_en with jmp_en starts a normal fetch.
        discard_nxt = 1'b0;
        if (fetch_en) begin
`ifdef IF_ALIGN_CHECK_EN
          if (addr_instr[1:0] != 2'b00) begin
            vld_nxt   = 1'b1;
            err_nxt   = 1'b1;
            instr_nxt = NOP_INSTR;
          end else begin
            araddr_nxt  = addr_instr;
            arvalid_nxt = 1'b1;
            idle_nxt    = 1'b0;
            state_nxt   = ADDR;
          end
`else
          araddr_nxt  = addr_instr;
          arvalid_nxt = 1'b1;
          idle_nxt    = 1'b0;
          state_nxt   = ADDR;
`endif
        end
      end

      ADDR: begin
        if (jmp_en) begin
          discard_nxt = 1'b1;
        end
        // arvalid stays asserted until accepted, as AXI requires.
        if (arvalid_q && axi.arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RESP;
        end
      end

      RESP: begin
        if (jmp_en) begin
          discard_nxt = 1'b1;
        end
        if (axi.rvalid) begin
          rready_nxt  = 1'b0;
          idle_nxt    = 1'b1;
          discard_nxt = 1'b0;
          state_nxt   = IDLE;
          // A redirect coinciding with rvalid also makes this data stale.
          if (discard_q || jmp_en) begin
            instr_nxt = NOP_INSTR;
          end else begin
            vld_nxt   = 1'b1;
            err_nxt   = (axi.rresp != 2'b00);
            instr_nxt = resp_instr(axi.rresp, axi.rdata);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign axi.araddr  = araddr_q;
  assign axi.arprot  = 3'b100;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi_idle_if = idle_q;
  assign instr       = instr_q;
  assign instr_vld   = vld_q;
  assign instr_err   = err_q;

endmodule

// File: doc/if_axi_rd.md
IF_AXI_RD -- requirements
Module: if_axi_rd

Interface
REQ-001 Parameter ADDR_W, default 32, instruction address width; matches the PC output bus.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, instruction driven on discard or error.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  pipeline permits a new fetch (hold released).
REQ-007 addr_instr  input  ADDR_W  fetch address from the PC.
REQ-008 jmp_en  input  1  redirect; the outstanding fetch becomes stale.
REQ-009 axi_idle_if  output  1  fetch port idle; the PC advances only while this is high.
REQ-010 instr  output  DATA_W  fetched instruction.
REQ-011 instr_vld  output  1  one-cycle strobe: instr is valid.
REQ-012 instr_err  output  1  qualifies instr_vld: bus error or misaligned access.
REQ-013 araddr  output  ADDR_W  AXI4-Lite read address.
REQ-014 arprot  output  3  constant 3'b100 (instruction, secure, unprivileged).
REQ-015 arvalid  output  1  / arready  input  1  AR handshake.
REQ-016 rdata  input  DATA_W  / rresp  input  2  / rvalid  input  1  / rready  output  1  R channel.

Function
REQ-017 FSM states: IDLE, ADDR, RESP; all outputs registered.
REQ-018 IDLE: axi_idle_if=1; when fetch_en=1, latch addr_instr into araddr, go to ADDR, axi_idle_if=0 next cycle.
REQ-019 ADDR: arvalid=1, araddr stable; on arvalid&arready go to RESP; arvalid is never withdrawn before arready.
REQ-020 RESP: rready=1; on rvalid go to IDLE, set axi_idle_if=1, pulse instr_vld for exactly one cycle.
REQ-021 Minimum latency: fetch_en at cycle N, arready at N+1, rvalid at N+2 -> instr_vld and axi_idle_if=1 at N+3.
REQ-022 rresp==2'b00: instr=rdata, instr_err=0; rresp!=2'b00: instr=NOP_INSTR, instr_err=1.
REQ-023 jmp_en in ADDR or RESP sets a discard flag; the AXI transaction still completes.
REQ-024 A discarded response produces no instr_vld, instr=NOP_INSTR, axi_idle_if=1 as normal; the flag clears on return to IDLE.
REQ-025 jmp_en in the same cycle as rvalid discards that response.
REQ-026 jmp_en in IDLE has no effect; fetch_en and jmp_en together in IDLE start the fetch normally (the PC supplies the redirected address).
REQ-027 At most one outstanding transaction; fetch_en is ignored outside IDLE.
REQ-028 instr holds its last value between strobes.

Reset
REQ-029 rst=1 forces IDLE, axi_idle_if=1, arvalid=0, rready=0, instr_vld=0, instr_err=0, instr=NOP_INSTR, araddr=0, discard flag=0, regardless of state.
REQ-030 Reset mid-transaction abandons the transfer; the AXI slave shares rst.

Configuration
REQ-031 Macro IF_ALIGN_CHECK_EN, when defined: fetch_en in IDLE with addr_instr[1:0]!=0 issues no AR; next cycle instr_vld=1, instr_err=1, instr=NOP_INSTR, FSM stays IDLE.
REQ-032 Without IF_ALIGN_CHECK_EN: addr_instr[1:0] is ignored and every fetch goes to the bus unchanged.

Verification
REQ-033 Reset, then fetch_en at addr 0x80000000, arready immediate, rvalid next cycle with rdata 0x00500093 -> instr_vld at N+3, instr=0x00500093, instr_err=0.
REQ-034 arready delayed 5 cycles -> arvalid held high and araddr stable all 5 cycles, axi_idle_if=0 throughout.
REQ-035 rresp=2'b10 -> instr_vld=1, instr_err=1, instr=0x00000013.
REQ-036 jmp_en during RESP, then rvalid -> no instr_vld, axi_idle_if=1, next fetch at 0x80000100 returns normally.
REQ-037 rst asserted in ADDR -> next cycle arvalid=0, axi_idle_if=1, instr=0x00000013.
REQ-038 With IF_ALIGN_CHECK_EN, fetch at 0x80000002 -> arvalid stays 0, instr_vld=1, instr_err=1 next cycle.
